// File: rtl/uart_pkg.sv
// Types and helpers for the UART TX/RX blocks: FSM state encoding, frame width, counter sizing.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

    localparam int UART_DATA_BITS = 8;

    function automatic int baud_cnt_width(input int clks_per_bit);
        return ($clog2(clks_per_bit) < 1) ? 1 : $clog2(clks_per_bit);
    endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and wraps; bit_end flags the last cycle of a period.
// Held at zero while clear is high so the first period after a clear is full length.
module uart_baud_counter
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic bit_end
);

    localparam int W = baud_cnt_width(CLKS_PER_BIT);
    localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

    logic [W-1:0] count_q;

    assign bit_end = (count_q == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (clear || bit_end) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART 8N1/8N2 TX framer driving an external shift register; accept-to-start latency 1 cycle.
// Backpressure: tx_ready only in IDLE (and never during reset); tx_valid elsewhere is ignored.
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       sr_load,
    output logic       sr_shift_en,
    output logic [7:0] sr_data,
    input  logic       sr_serial_in,
    output logic       tx,
    output logic       busy,
    output logic       tx_done
);

    localparam logic [2:0] LAST_BIT  = 3'(UART_DATA_BITS - 1);
    localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

    tx_state_t  state_q;
    logic [2:0] bit_idx_q;
    logic       tx_done_q;
    logic       bit_end;

    // Counter idles at zero, so every state entry starts a fresh bit period.
    uart_baud_counter #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk    (clk),
        .rst    (rst),
        .clear  (state_q == IDLE),
        .bit_end(bit_end)
    );

    assign tx_ready    = (state_q == IDLE) && !rst;
    assign sr_load     = tx_valid && tx_ready;
    assign sr_data     = tx_data;
    assign sr_shift_en = (state_q == DATA) && bit_end;
    assign busy        = (state_q != IDLE);
    assign tx_done     = tx_done_q;

    // Line level depends only on registered state and the shift register output.
    always_comb begin
        tx = 1'b1;
        case (state_q)
            START:   tx = 1'b0;
            DATA:    tx = sr_serial_in;
            default: tx = 1'b1;
        endcase
    end

    // bit_idx counts data bits in DATA and stop bits in STOP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            bit_idx_q <= '0;
            tx_done_q <= 1'b0;
        end else begin
            tx_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (sr_load) begin
                        state_q <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        state_q   <= DATA;
                        bit_idx_q <= '0;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bit_idx_q == LAST_BIT) begin
                            state_q   <= STOP;
                            bit_idx_q <= '0;
                        end else begin
                            bit_idx_q <= bit_idx_q + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        if (bit_idx_q == LAST_STOP) begin
                            state_q   <= IDLE;
                            bit_idx_q <= '0;
                            tx_done_q <= 1'b1;
                        end else begin
                            bit_idx_q <= bit_idx_q + 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: two instances (1 and 2 stop bits) each with a behavioural shift register.
module tb_uart_tx_ctrl;

    localparam int C = 4;

    logic       clk;
    logic       rst;
    logic       sel;
    logic       vin;
    logic [7:0] din;

    int checks = 0;
    int errors = 0;

    logic       vld_a, rdy_a, load_a, sh_a, ser_a, tx_a, busy_a, done_a;
    logic [7:0] srd_a, sr_a;
    logic       vld_b, rdy_b, load_b, sh_b, ser_b, tx_b, busy_b, done_b;
    logic [7:0] srd_b, sr_b;

    assign vld_a = vin & ~sel;
    assign vld_b = vin & sel;
    assign ser_a = sr_a[0];
    assign ser_b = sr_b[0];

    uart_tx_ctrl #(.CLKS_PER_BIT(C), .STOP_BITS(1)) dut_a (
        .clk(clk), .rst(rst), .tx_data(din), .tx_valid(vld_a), .tx_ready(rdy_a),
        .sr_load(load_a), .sr_shift_en(sh_a), .sr_data(srd_a), .sr_serial_in(ser_a),
        .tx(tx_a), .busy(busy_a), .tx_done(done_a)
    );

    uart_tx_ctrl #(.CLKS_PER_BIT(C), .STOP_BITS(2)) dut_b (
        .clk(clk), .rst(rst), .tx_data(din), .tx_valid(vld_b), .tx_ready(rdy_b),
        .sr_load(load_b), .sr_shift_en(sh_b), .sr_data(srd_b), .sr_serial_in(ser_b),
        .tx(tx_b), .busy(busy_b), .tx_done(done_b)
    );

    always @(posedge clk) begin
        if (load_a) sr_a <= srd_a;
        else if (sh_a) sr_a <= {1'b0, sr_a[7:1]};
        if (load_b) sr_b <= srd_b;
        else if (sh_b) sr_b <= {1'b0, sr_b[7:1]};
    end

    logic       o_tx, o_rdy, o_load, o_sh, o_busy, o_done;
    logic [7:0] o_srd;
    assign o_tx   = sel ? tx_b   : tx_a;
    assign o_rdy  = sel ? rdy_b  : rdy_a;
    assign o_load = sel ? load_b : load_a;
    assign o_sh   = sel ? sh_b   : sh_a;
    assign o_busy = sel ? busy_b : busy_a;
    assign o_done = sel ? done_b : done_a;
    assign o_srd  = sel ? srd_b  : srd_a;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference: line level at cycle k (1-based) after the accept cycle.
    function automatic logic exp_tx(input logic [7:0] d, input int k);
        int b;
        b = (k - 1) / C;
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
        return 1'b1;
    endfunction

    function automatic logic exp_shift(input int k);
        int b;
        b = (k - 1) / C;
        return (b >= 1) && (b <= 8) && ((k % C) == 0);
    endfunction

    task automatic idle(input int n);
        vin = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #2;
            chk("idle_tx", o_tx, 1'b1);
            chk("idle_ready", o_rdy, 1'b1);
            chk("idle_busy", o_busy, 1'b0);
            chk("idle_done", o_done, 1'b0);
            chk("idle_load", o_load, 1'b0);
        end
    endtask

    task automatic run_frame(input logic [7:0] d, input int sb, input logic nxt_vld,
                             input logic [7:0] nxt_d, input int glitch_k, input int abort_k);
        int   len;
        logic got;
        len = (9 + sb) * C;
        got = 1'b0;
        vin = 1'b1;
        din = d;
        for (int i = 0; i < 200; i++) begin
            #1;
            if (o_rdy === 1'b1) begin
                chk("accept_load", o_load, 1'b1);
                chk("accept_sr_data", o_srd, d);
                got = 1'b1;
                break;
            end
            chk("wait_load", o_load, 1'b0);
            @(posedge clk); #1;
        end
        chk("accept_seen", got, 1'b1);
        if (got !== 1'b1) return;
        for (int k = 1; k <= len + 1; k++) begin
            @(posedge clk); #1;
            vin = nxt_vld;
            din = nxt_vld ? nxt_d : d;
            if (k == glitch_k) begin
                vin = 1'b1;
                din = 8'h12;
            end
            if (k == abort_k) rst = 1'b1;
            #1;
            if (k == abort_k) begin
                chk("abort_tx", o_tx, 1'b1);
                chk("abort_busy", o_busy, 1'b0);
                chk("abort_ready", o_rdy, 1'b0);
                chk("abort_load", o_load, 1'b0);
                return;
            end
            if (k <= len) begin
                chk($sformatf("tx_k%0d", k), o_tx, exp_tx(d, k));
                chk($sformatf("shift_k%0d", k), o_sh, exp_shift(k));
                chk("frame_ready", o_rdy, 1'b0);
                chk("frame_busy", o_busy, 1'b1);
                chk("frame_done", o_done, 1'b0);
                chk("frame_load", o_load, 1'b0);
            end else begin
                chk("end_done", o_done, 1'b1);
                chk("end_ready", o_rdy, 1'b1);
                chk("end_busy", o_busy, 1'b0);
                chk("end_tx", o_tx, 1'b1);
                chk("end_load", o_load, nxt_vld);
            end
        end
    endtask

    initial begin
        logic [7:0] d;
        rst = 1'b1;
        sel = 1'b0;
        vin = 1'b1;
        din = 8'h55;
        repeat (2) @(posedge clk);
        #2;
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            chk("rst_tx", o_tx, 1'b1);
            chk("rst_ready", o_rdy, 1'b0);
            chk("rst_busy", o_busy, 1'b0);
            chk("rst_done", o_done, 1'b0);
            chk("rst_load", o_load, 1'b0);
        end
        vin = 1'b0;
        rst = 1'b0;
        @(posedge clk); #2;
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            chk("post_rst_ready", o_rdy, 1'b1);
            chk("post_rst_busy", o_busy, 1'b0);
        end
        #1;
        sel = 1'b0;

        run_frame(8'hA5, 1, 1'b0, 8'h00, 0, 0);
        idle(2);

        run_frame(8'h00, 1, 1'b1, 8'hFF, 0, 0);
        run_frame(8'hFF, 1, 1'b0, 8'h00, 0, 0);
        idle(2);

        run_frame(8'h5A, 1, 1'b0, 8'h00, 10, 0);
        idle(3);

        // Abort during data bit 3 (line bit 4 covers k = 17..20).
        run_frame(8'hC3, 1, 1'b0, 8'h00, 0, 18);
        vin = 1'b0;
        @(posedge clk); #2;
        chk("in_rst_tx", o_tx, 1'b1);
        chk("in_rst_done", o_done, 1'b0);
        chk("in_rst_busy", o_busy, 1'b0);
        rst = 1'b0;
        idle(3);
        run_frame(8'h3C, 1, 1'b0, 8'h00, 0, 0);
        idle(1);

        for (int n = 0; n < 8; n++) begin
            d = 8'($urandom);
            run_frame(d, 1, 1'b0, 8'h00, 0, 0);
            idle(int'($urandom_range(0, 2)));
        end

        sel = 1'b1;
        run_frame(8'h81, 2, 1'b0, 8'h00, 0, 0);
        idle(2);
        for (int n = 0; n < 4; n++) begin
            d = 8'($urandom);
            run_frame(d, 2, 1'b0, 8'h00, 0, 0);
            idle(int'($urandom_range(0, 2)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
UART transmit framer/controller that sits directly upstream of the TX shift register stage. It accepts bytes over a valid/ready handshake, generates bit timing from a clock-cycle baud counter, and drives the shift register's load, shift-enable and data inputs. It consumes the shift register's serial output and muxes it with the start and stop bits to form the 8N1 (or 8N2) line output.

Parameters:
CLKS_PER_BIT, 868, clock cycles per bit period (at least 2; 868 gives 115200 baud at 100 MHz).
STOP_BITS, 1, number of stop bits; legal values are 1 and 2.

Ports:
clk  input  1  system clock; all state changes on its rising edge.
rst  input  1  asynchronous, active-high reset.
tx_data  input  8  byte to transmit; sampled on the accept cycle.
tx_valid  input  1  upstream byte available.
tx_ready  output  1  controller can accept a byte.
sr_load  output  1  to shift register load; one-cycle pulse.
sr_shift_en  output  1  to shift register shift_en; one-cycle pulse per data bit.
sr_data  output  8  to shift register data_in.
sr_serial_in  input  1  from shift register serial_out (current LSB).
tx  output  1  UART line; idles high.
busy  output  1  a frame is in progress.
tx_done  output  1  one-cycle pulse after the stop bit completes.

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high.
- While rst is high:
  - state = IDLE; baud counter, bit index and tx_done are 0.
  - tx = 1, busy = 0.
  - tx_ready = 0 and sr_load = 0, so no byte can be accepted during reset.
- State machine: IDLE -> START -> DATA -> STOP -> IDLE.
- Baud counter:
  - 0 to CLKS_PER_BIT-1; cleared on every state entry.
  - bit_end = (count == CLKS_PER_BIT-1).
- IDLE:
  - tx_ready = 1.
  - On tx_valid && tx_ready (the accept cycle):
    - sr_load = 1 combinationally in that cycle.
    - sr_data = tx_data.
    - Next state is START.
  - sr_data is a pass-through of tx_data at all times.
- START: tx = 0 for CLKS_PER_BIT cycles, then go to DATA with bit_idx = 0.
- DATA:
  - tx = sr_serial_in for each bit period.
  - sr_shift_en = 1 in the last cycle of every bit period (bit_end), including bit 7.
  - On bit_end, bit_idx increments; after bit_idx = 7 completes, go to STOP.
  - The register update lands on the next edge, so bit k+1 is on tx from the first cycle of period k+1.
  - Data is sent LSB first.
- STOP: tx = 1 for STOP_BITS*CLKS_PER_BIT cycles, then go to IDLE.
- tx_done:
  - Registered; high exactly for the first IDLE cycle after STOP.
  - This is also the first cycle in which tx_ready = 1 again.
- tx is decoded combinationally from the registered state and sr_serial_in only: START -> 0, DATA -> sr_serial_in, otherwise 1. No other combinational input may reach tx.
- busy = (state != IDLE).
- Frame length is 1 + 8 + STOP_BITS bit periods. With tx_valid held high, the minimum accept-to-accept spacing is (9+STOP_BITS)*CLKS_PER_BIT + 1 cycles.
- tx_valid while not IDLE:
  - Ignored: no sr_load, and tx_data is not sampled.
  - Upstream holds tx_valid and tx_data until it sees tx_ready.
- Reset mid-frame: tx returns to 1 immediately (asynchronous), the frame is aborted, and no tx_done is produced. The next frame after reset is fully correct.
- The shift register's own done output is not used; this block owns bit counting.

Decomposition:
- Package uart_pkg holds:
  - typedef enum tx_state_t {IDLE, START, DATA, STOP};
  - constant UART_DATA_BITS = 8;
  - a function returning $clog2 of CLKS_PER_BIT for the counter width.
- One sub-module: uart_baud_counter (clk, rst, clear, bit_end), parameterised by CLKS_PER_BIT and reusable by the RX side.
- FSM and bit index stay in uart_tx_ctrl.
- The bench instantiates uart_tx_ctrl with the TX shift register stage connected.

Test Plan:
All scenarios use CLKS_PER_BIT=4, STOP_BITS=1, with the shift register stage attached.
- Reset: rst high -> tx=1, tx_ready=0, busy=0, tx_done=0; rst low -> tx_ready=1 on the next cycle.
- Send 0xA5, accepted at cycle T:
  - sr_load pulses at T.
  - tx=0 over T+1..T+4.
  - tx bits 1,0,1,0,0,1,0,1 in 4-cycle periods over T+5..T+36.
  - tx=1 over T+37..T+40.
  - tx_done=1 and tx_ready=1 at T+41.
  - Exactly 8 sr_shift_en pulses, at T+8, T+12, …, T+36.
- tx_valid held high with 0x00 then 0xFF: second accept at T+41; tx_ready=0 over T+1..T+40; both frames are bit-exact on tx.
- tx_valid pulsed with 0x12 at T+10 (mid-frame): no sr_load and tx_ready stays 0; the first frame is unchanged on tx and no second frame starts.
- rst asserted during DATA bit 3: tx=1 in the same cycle, no tx_done; after release, send 0x3C -> correct frame 0,0,0,1,1,1,1,0,0,1.
- STOP_BITS=2, send 0x81: tx=1 over T+37..T+44, tx_done at T+45, busy=0 from T+45.
